// File: rtl/cella_seq_pkg.sv
// Shared types and constants for the column access sequencer.
// State encoding, opcode values and decoder field widths.
package cella_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_DRIVE = 3'd2,
    ST_PRE   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic OP_CAM = 1'b0;
  localparam logic OP_MAC = 1'b1;

  localparam int COL_ADDR_W = 3;
  localparam int COL_DATA_W = 8;

endpackage

// File: rtl/col_phase_timer.sv
// Loadable down-counter timing the DRIVE and PRE phases.
// Latency: load value visible the cycle after load; zero flag is combinational.
// Backpressure: none; load overrides the decrement.
module col_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/col_access_seq.sv
// Column decoder sequencer: holds MAC_en/addr/data, strobes drive then precharge, pulses done.
// Latency: done in cycle k+2+DRIVE_CYCLES+PRE_CYCLES after acceptance on edge k.
// Backpressure: cmd_ready only in IDLE; with COL_SEQ_SKID_EN a one-entry skid sets cmd_ready = !skid_full.
module col_access_seq
  import cella_seq_pkg::*;
#(
  parameter int DRIVE_CYCLES = 2,
  parameter int PRE_CYCLES   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op,
  input  logic [COL_ADDR_W-1:0] cmd_addr,
  input  logic [COL_DATA_W-1:0] cmd_data,
  output logic                  MAC_en,
  output logic [COL_ADDR_W-1:0] addr,
  output logic [COL_DATA_W-1:0] data,
  output logic                  drive_en,
  output logic                  precharge,
  output logic                  busy,
  output logic                  done
);

  localparam int MAX_CYC = (DRIVE_CYCLES > PRE_CYCLES) ? DRIVE_CYCLES : PRE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  state_t           state, state_nxt;
  logic             accept;
  logic             load_cmd, load_skid;
  logic             tmr_load, tmr_zero;
  logic [CNT_W-1:0] tmr_val;
  logic             src_op;
  logic [COL_ADDR_W-1:0] src_addr;
  logic [COL_DATA_W-1:0] src_data;

`ifdef COL_SEQ_SKID_EN
  logic                  skid_full;
  logic                  skid_op;
  logic [COL_ADDR_W-1:0] skid_addr;
  logic [COL_DATA_W-1:0] skid_data;

  assign cmd_ready = !skid_full;
`else
  assign cmd_ready = (state == ST_IDLE);
`endif

  assign accept = cmd_valid && cmd_ready;

  always_comb begin
    state_nxt = state;
    load_cmd  = 1'b0;
    load_skid = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_SETUP;
          load_cmd  = 1'b1;
        end
      end
      ST_SETUP: begin
        state_nxt = ST_DRIVE;
        tmr_load  = 1'b1;
        tmr_val   = CNT_W'(DRIVE_CYCLES - 1);
      end
      ST_DRIVE: begin
        if (tmr_zero) begin
          state_nxt = ST_PRE;
          tmr_load  = 1'b1;
          tmr_val   = CNT_W'(PRE_CYCLES - 1);
        end
      end
      ST_PRE: begin
        if (tmr_zero) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
`ifdef COL_SEQ_SKID_EN
        // Pending skid entry goes first to keep FIFO order.
        if (skid_full) begin
          state_nxt = ST_SETUP;
          load_skid = 1'b1;
        end else if (accept) begin
          state_nxt = ST_SETUP;
          load_cmd  = 1'b1;
        end
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef COL_SEQ_SKID_EN
  always_comb begin
    src_op   = cmd_op;
    src_addr = cmd_addr;
    src_data = cmd_data;
    if (load_skid) begin
      src_op   = skid_op;
      src_addr = skid_addr;
      src_data = skid_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_full <= 1'b0;
      skid_op   <= OP_CAM;
      skid_addr <= '0;
      skid_data <= '0;
    end else begin
      if (load_skid) skid_full <= 1'b0;
      if (accept && state != ST_IDLE && state != ST_DONE) begin
        skid_full <= 1'b1;
        skid_op   <= cmd_op;
        skid_addr <= cmd_addr;
        skid_data <= cmd_data;
      end
    end
  end
`else
  assign src_op   = cmd_op;
  assign src_addr = cmd_addr;
  assign src_data = cmd_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Decoder inputs change only on a load; the unused field is forced to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      MAC_en <= 1'b0;
      addr   <= '0;
      data   <= '0;
    end else if (load_cmd || load_skid) begin
      MAC_en <= (src_op == OP_MAC);
      addr   <= (src_op == OP_MAC) ? '0 : src_addr;
      data   <= (src_op == OP_MAC) ? src_data : '0;
    end
  end

  col_phase_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  assign drive_en  = (state == ST_DRIVE);
  assign precharge = (state == ST_IDLE) || (state == ST_PRE) || (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

endmodule

// File: doc/col_access_seq.md
Name: col_access_seq

Overview:
- Sequencer directly upstream of the column decoder in the CAM/MAC array.
- Accepts one command at a time over a valid/ready handshake: CAM column select or MAC word drive.
- Registers and holds the decoder inputs (MAC_en, column address, data word) stable for a fixed timing window.
- Generates the bitline drive and precharge strobes, then pulses completion.

Parameters:
- DRIVE_CYCLES, 2, cycles drive_en stays high; legal range >=1.
- PRE_CYCLES, 1, cycles of post-drive precharge; legal range >=1.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  1  0 = CAM column select, 1 = MAC.
- cmd_addr  in  3  column address; used for CAM only.
- cmd_data  in  8  MAC input word; used for MAC only.
- MAC_en  out  1  decoder mode select.
- addr  out  3  decoder address bits; addr[0] feeds addr0, and so on.
- data  out  8  decoder data bits; data[0] feeds data0, and so on.
- drive_en  out  1  bitline driver enable.
- precharge  out  1  bitline precharge enable.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: MAC_en=0, addr=0, data=0, drive_en=0, precharge=1, busy=0, done=0, cmd_ready=1, state=IDLE.
- Acceptance: a command is accepted on the edge where cmd_valid && cmd_ready.
- Base build: cmd_ready = (state==IDLE).
- Register loading on acceptance:
  - CAM: MAC_en<=0, addr<=cmd_addr, data<=0.
  - MAC: MAC_en<=1, addr<=0, data<=cmd_data.
  - The unused field is ignored.
- Hold rule: MAC_en, addr and data hold from SETUP through DONE and stay at their last value in IDLE. They change only on acceptance or reset.
- FSM:
  - IDLE: precharge=1.
  - SETUP: exactly 1 cycle; drive_en=0, precharge=0; outputs settle.
  - DRIVE: DRIVE_CYCLES cycles; drive_en=1, precharge=0.
  - PRE: PRE_CYCLES cycles; precharge=1, drive_en=0.
  - DONE: 1 cycle; done=1, precharge=1; then IDLE.
  - drive_en and precharge are never high together.
  - There is no cycle with both low except SETUP.
- Timing, with acceptance on edge k:
  - SETUP is the cycle after k.
  - DRIVE occupies the next DRIVE_CYCLES cycles.
  - PRE follows, then DONE.
  - done is high in cycle k+2+DRIVE_CYCLES+PRE_CYCLES; with defaults, the 5th cycle after acceptance.
  - Base command period: DRIVE_CYCLES+PRE_CYCLES+3 cycles (6 with defaults).
- Phase counter:
  - Down-counter of width clog2(max(DRIVE_CYCLES,PRE_CYCLES))+1.
  - Loaded with count-1 on phase entry; phase exits when counter==0.
- cmd_valid while busy (base build): ignored; the producer holds it. cmd_* may change while not ready without effect.
- Reset mid-operation:
  - Next edge forces IDLE and all reset values.
  - No done pulse; the in-flight command is dropped.
  - Also drops the skid entry when the optional feature is built.
- Simultaneous rst and cmd_valid: rst wins; no acceptance.

Optional Feature:
- Macro: COL_SEQ_SKID_EN.
- With the macro:
  - One-entry skid register; cmd_ready = !skid_full (independent of state).
  - A command accepted while busy is stored in the skid.
  - In DONE, if the skid is full, the next state is SETUP: outputs load from the skid and the skid clears.
  - A command arriving in DONE with the skid empty is also taken directly into SETUP.
  - Back-to-back period drops to DRIVE_CYCLES+PRE_CYCLES+2 cycles.
  - Ordering is strictly FIFO.
- Without the macro: base behaviour above; no skid logic is synthesised.

Decomposition:
- Package cella_seq_pkg:
  - State enum (IDLE, SETUP, DRIVE, PRE, DONE).
  - OP_CAM=1'b0, OP_MAC=1'b1.
  - COL_ADDR_W=3, COL_DATA_W=8.
- One sub-module, col_phase_timer: loadable down-counter with load value, load strobe and zero flag; reused for the DRIVE and PRE phases.

Test Plan:
- Reset then idle → MAC_en=0, addr=0, data=0, precharge=1, drive_en=0, cmd_ready=1, done=0.
- CAM op, cmd_addr=3'd5, defaults → addr=5, MAC_en=0, data=0; drive_en high exactly 2 cycles starting 2nd cycle after accept; done in 5th cycle; cmd_ready back in 6th.
- MAC op, cmd_data=8'hA5 with cmd_addr=3'd7 → MAC_en=1, data=A5, addr=0, held through DONE; changing cmd_data while busy leaves data=A5.
- cmd_valid held continuously with two commands (CAM 2, MAC 3C) → second accepted only in IDLE; period 6 cycles base, 5 with COL_SEQ_SKID_EN; FIFO order preserved.
- rst asserted during DRIVE → next cycle IDLE, precharge=1, drive_en=0, addr/data/MAC_en=0, no done pulse.
- DRIVE_CYCLES=1, PRE_CYCLES=3 → 1 drive cycle, 3 precharge cycles, done in 6th cycle after accept; drive_en and precharge never both high.
